// File: rtl/mips_cpu_avalon_arbiter.sv
// Two-master / one-slave Avalon-MM arbiter: one single-word transfer per grant, round-robin on contention.
// Optional ARB_LOCK_EN macro adds mN_lock inputs that hold ownership across back-to-back completions.
module mips_cpu_avalon_arbiter #(
  parameter int ADDR_W    = 32,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  input  logic [3:0]        m0_byteenable,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  input  logic [3:0]        m1_byteenable,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
`ifdef ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [31:0]       s_writedata,
  output logic [3:0]        s_byteenable,
  input  logic              s_waitrequest,
  input  logic [31:0]       s_readdata,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e state_q, state_d;
  logic   lw_q, lw_d;
  logic   req0, req1, lock0, lock1, own0, own1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef ARB_LOCK_EN
  assign lock0 = m0_lock;
  assign lock1 = m1_lock;
`else
  assign lock0 = 1'b0;
  assign lock1 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      lw_q    <= ~INIT_PRIO;
    end else begin
      state_q <= state_d;
      lw_q    <= lw_d;
    end
  end

  // A withdrawn request drops ownership without touching lw, so nobody gains priority from it.
  always_comb begin
    state_d = state_q;
    lw_d    = lw_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = lw_q ? OWN0 : OWN1;
        else if (req0)    state_d = OWN0;
        else if (req1)    state_d = OWN1;
      end
      OWN0: begin
        if (!req0) state_d = IDLE;
        else if (!s_waitrequest) begin
          lw_d    = 1'b0;
          state_d = lock0 ? OWN0 : IDLE;
        end
      end
      OWN1: begin
        if (!req1) state_d = IDLE;
        else if (!s_waitrequest) begin
          lw_d    = 1'b1;
          state_d = lock1 ? OWN1 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the bus outputs immediately so an abandoned transfer never strobes the slave.
  assign own0 = reset && (state_q == OWN0);
  assign own1 = reset && (state_q == OWN1);

  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    grant          = 2'b00;
    if (own0) begin
      s_address      = m0_address;
      s_read         = m0_read;
      s_write        = m0_write;
      s_writedata    = m0_writedata;
      s_byteenable   = m0_byteenable;
      m0_waitrequest = s_waitrequest;
      grant          = 2'b01;
    end else if (own1) begin
      s_address      = m1_address;
      s_read         = m1_read;
      s_write        = m1_write;
      s_writedata    = m1_writedata;
      s_byteenable   = m1_byteenable;
      m1_waitrequest = s_waitrequest;
      grant          = 2'b10;
    end
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule

// File: doc/mips_cpu_avalon_arbiter.md
Name: mips_cpu_avalon_arbiter

Overview:
- Two-master, one-slave arbiter for the Avalon memory-mapped bus used by the CPU.
- Port m0 connects to the CPU bus controller (mem_address/memread/memwrite/...); port m1 connects to a second requester (DMA/debug loader). Both share one memory slave.
- Grants one single-word transfer at a time: round-robin on contention, fixed tie-break after reset.
- Stalls the losing master by holding its waitrequest high.

Parameters:
- ADDR_W, 32, address width for both masters and the slave.
- INIT_PRIO, 0, master that wins the first simultaneous request after reset (0 or 1).

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  synchronous, active-low reset.
- m0_address  in  ADDR_W  master 0 address.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_writedata  in  32  master 0 write data.
- m0_byteenable  in  4  master 0 byte lanes.
- m0_waitrequest  out  1  master 0 stall.
- m0_readdata  out  32  master 0 read data.
- m1_* : identical set for master 1.
- s_address  out  ADDR_W  slave address.
- s_read  out  1  slave read strobe.
- s_write  out  1  slave write strobe.
- s_writedata  out  32  slave write data.
- s_byteenable  out  4  slave byte lanes.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  32  slave read data.
- grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle.

Behaviour:
- States: IDLE, OWN0, OWN1, held in a register. Registered last-winner bit lw.
- Reset (reset==0 at posedge): state=IDLE, lw=~INIT_PRIO. This applies mid-transfer too; the in-flight transfer is abandoned, with no completion reported to the master.
- Output values during reset and IDLE: s_read=s_write=0, s_address=s_writedata=0, s_byteenable=0, grant=00, m0_waitrequest=m1_waitrequest=1, m*_readdata=s_readdata.
- reqN = mN_read | mN_write.
- IDLE: only req0 -> OWN0; only req1 -> OWN1; both -> the master != lw; none -> stay.
- Grant latency: request seen in IDLE at cycle T, slave strobes driven at T+1. A transfer therefore costs at least 2 cycles.
- OWNn, combinational outputs:
  - s_* = mn_* (read, write, address, writedata, byteenable).
  - mn_waitrequest = s_waitrequest; other master's waitrequest = 1.
  - grant bit n = 1.
- OWNn completion = reqn & ~s_waitrequest. On completion: lw<=n, next state=IDLE (no back-to-back grant). The other master gets the next IDLE decision if requesting.
- OWNn with reqn==0 (master withdrew; protocol violation): return to IDLE next cycle, lw unchanged.
- mn_read & mn_write both high: forwarded unchanged; the arbiter does not arbitrate within a master.
- Strict round-robin: no master waits more than one completed foreign transfer once its request is visible in IDLE.
- No internal buffering: write data and address are not registered; the master holds them stable while waitrequest=1.

Optional Feature:
- ARB_LOCK_EN: adds input mN_lock (1 bit) per master.
- With the macro: in OWNn, a completion with mn_lock==1 keeps state OWNn (lw still <=n), giving back-to-back transfers with no IDLE cycle. When lock drops, the next completion releases normally. Lock is ignored in IDLE.
- Without the macro: no lock ports; every completion returns to IDLE.

Test Plan:
- Single master: m0_read=1, m0_address=0xBFC00000, s_waitrequest=0, s_readdata=0x8C020004. Required: grant=01 one cycle later; s_read=1, s_address=0xBFC00000 that cycle; m0_waitrequest=0 and m0_readdata=0x8C020004 that cycle; state IDLE next cycle.
- Contention after reset (INIT_PRIO=0): m0 and m1 both write from cycle 0 (m1_writedata=0x12345678). Required: m0 owns first; m1_waitrequest=1 throughout m0's transfer; m1 granted on the next IDLE decision; s_writedata=0x12345678 while grant=10.
- Round-robin: both masters request continuously for 8 transfers. Required: grant alternates 01,10,01,...; exactly 4 completions each.
- Slave stall: m1 read with s_waitrequest=1 for 3 cycles. Required: grant=10 held, m1_waitrequest=1 for those 3 cycles; completion on the 4th; m0 request raised meanwhile is not granted until IDLE.
- Reset mid-transfer: reset=0 while grant=01 and s_waitrequest=1. Required: next cycle grant=00, s_read=s_write=0, both waitrequests=1. After release, a simultaneous request goes to m0 (INIT_PRIO=0).
- ARB_LOCK_EN defined: m0_lock=1 for 3 reads with s_waitrequest=0. Required: grant=01 continuously, 3 completions in 3 consecutive cycles, m1 (requesting) granted only after lock drops.
